demod_segment_array: RTL



---
 rtl/demod_segment_array.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/demod_segment_array.sv
// Multi-segment demodulator: integrates SPS samples per segment over NUM_SEG segments and hard-decides each one.
// Optional DEMOD_SEG_SOFT_EN adds min_metric, the smallest |acc| seen across the segments of the last run.
module demod_segment_array #(
   parameter int DATA_W    = 32,
   parameter int FRAC_W    = 16,
   parameter int NUM_SEG   = 10,
   parameter int SPS       = 1,
   parameter int REF_PHASE = 0,
   parameter int ACC_W     = DATA_W + $clog2(SPS) + 1
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        start,
   input  logic [DATA_W-1:0]           in_data,
   input  logic                        in_valid,
   output logic                        in_ready,
   output logic [NUM_SEG*DATA_W-1:0]   seg_out,
   output logic [NUM_SEG-1:0]          seg_bits,
   output logic                        valid,
`ifdef DEMOD_SEG_SOFT_EN
   output logic [ACC_W-1:0]            min_metric,
`endif
   output logic                        busy
);

   localparam int SPS_CW = (SPS > 1) ? $clog2(SPS) : 1;
   localparam int SEG_CW = (NUM_SEG > 1) ? $clog2(NUM_SEG) : 1;
   localparam logic [DATA_W-1:0] REF_POS = DATA_W'(1) << FRAC_W;
   localparam logic [DATA_W-1:0] REF_NEG = ~REF_POS + DATA_W'(1);
   localparam logic [SPS_CW-1:0] LAST_S  = SPS_CW'(SPS - 1);
   localparam logic [SEG_CW-1:0] LAST_K  = SEG_CW'(NUM_SEG - 1);

   typedef enum logic [1:0] {
      IDLE,
      ACCUM,
      DONE
   } state_t;

   state_t state, next_state;

   logic [ACC_W-1:0]  acc;
   logic [ACC_W-1:0]  acc_sum;
   logic [SPS_CW-1:0] s;
   logic [SEG_CW-1:0] k;
   logic              start_run;
   logic              accept;
   logic              last_sample;
   logic              last_seg;
   logic              ref_pos;
   logic              decide_ref;
   logic [DATA_W-1:0] dec_val;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      in_ready   = 1'b0;
      valid      = 1'b0;
      busy       = 1'b0;
      start_run  = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               next_state = ACCUM;
               start_run  = 1'b1;
            end
         end
         ACCUM: begin
            in_ready = 1'b1;
            busy     = 1'b1;
            if (in_valid && last_sample && last_seg) begin
               next_state = DONE;
            end
         end
         DONE: begin
            valid      = 1'b1;
            busy       = 1'b1;
            next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   assign accept      = in_ready && in_valid;
   assign last_sample = (s == LAST_S);
   assign last_seg    = (k == LAST_K);
   assign acc_sum     = acc + {{(ACC_W-DATA_W){in_data[DATA_W-1]}}, in_data};

   // A zero sum is a tie and resolves toward the segment's own reference.
   assign ref_pos    = (k[0] == (REF_PHASE != 0));
   assign decide_ref = (acc_sum == '0) || (acc_sum[ACC_W-1] != ref_pos);
   assign dec_val    = (decide_ref == ref_pos) ? REF_POS : REF_NEG;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc      <= '0;
         s        <= '0;
         k        <= '0;
         seg_out  <= '0;
         seg_bits <= '0;
      end else if (start_run) begin
         acc      <= '0;
         s        <= '0;
         k        <= '0;
         seg_out  <= '0;
         seg_bits <= '0;
      end else if (accept) begin
         if (last_sample) begin
            acc <= '0;
            s   <= '0;
            k   <= last_seg ? '0 : k + SEG_CW'(1);
            for (int i = 0; i < NUM_SEG; i++) begin
               if (int'(k) == i) begin
                  seg_out[i*DATA_W +: DATA_W] <= dec_val;
                  seg_bits[i]                 <= decide_ref;
               end
            end
         end else begin
            acc <= acc_sum;
            s   <= s + SPS_CW'(1);
         end
      end
   end

`ifdef DEMOD_SEG_SOFT_EN
   logic [ACC_W-1:0] abs_sum;

   assign abs_sum = acc_sum[ACC_W-1] ? (~acc_sum + ACC_W'(1)) : acc_sum;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         min_metric <= '1;
      end else if (start_run) begin
         min_metric <= '1;
      end else if (accept && last_sample && (abs_sum < min_metric)) begin
         min_metric <= abs_sum;
      end
   end
`else
   // Hard decisions only; no soft metric is tracked.
`endif

endmodule
